am_tx_1b: RTL

One-bit AM transmitter: the transmit-direction counterpart of the 1-bit receive chain (NCO → mixer → CIC → AM demod). It accepts signed audio samples over a valid/ready handshake at the audio rate, linearly interpolates them up to the clock rate, and forms an AM envelope. It multiplies the envelope by an NCO square-wave carrier and drives a first-order delta-sigma 1-bit RF output pin.

---
 rtl/am_tx_1b.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/am_tx_1b.sv
// One-bit AM transmitter: audio handshake, linear interpolator up to the clock
// rate, AM envelope, square-wave NCO carrier and a first-order 1-bit
// delta-sigma modulator driving the RF pin.
`timescale 1ns / 1ps
module am_tx_1b #(
    parameter int unsigned PHASE_W  = 40,
    parameter int unsigned DIV_LOG2 = 10
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  phase_inc,
    input  logic [8:0]          mod_depth,
    input  logic signed [15:0]  audio_in,
    input  logic                audio_valid,
    output logic                audio_ready,
    output logic                underrun,
    output logic                rf_out
);

    localparam int unsigned IaW = 16 + DIV_LOG2;

    logic [DIV_LOG2-1:0]  div_cnt_q, div_cnt_d;
    logic                 boundary;
    logic                 accept;
    logic signed [15:0]   hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic signed [15:0]   cur_q, cur_d;
    logic signed [15:0]   target_q, target_d;
    logic                 underrun_q, underrun_d;
    logic signed [IaW-1:0] ia_q, ia_d;
    logic signed [16:0]   step;
    logic signed [15:0]   interp;
    logic [8:0]           md;
    logic signed [25:0]   prod;
    logic [15:0]          env;
    logic signed [17:0]   carrier;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic signed [17:0]   err_q, err_d;
    logic signed [18:0]   v;
    logic signed [18:0]   err_w;
    logic                 dsm_bit;
    logic                 rf_q, rf_d;
    logic                 unused_bits;

    // Frame counter; the all-ones cycle is the sample boundary.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_LOG2'(1);
        boundary  = (div_cnt_q == {DIV_LOG2{1'b1}});
    end

    // Holding register, sample pipeline (hold -> target -> cur) and sticky underrun.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cur_d       = cur_q;
        target_d    = target_q;
        underrun_d  = underrun_q;
        accept      = audio_valid && !hold_full_q;
        if (boundary) begin
            cur_d = target_q;
            if (hold_full_q) begin
                target_d    = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
        // A sample taken on the boundary cycle lands in hold; it is not consumed yet.
        if (accept) begin
            hold_d      = audio_in;
            hold_full_d = 1'b1;
        end
    end

    // Linear interpolator; reloaded exactly at every boundary so error never accumulates.
    always_comb begin
        step   = {target_q[15], target_q} - {cur_q[15], cur_q};
        interp = ia_q[IaW-1:DIV_LOG2];
        if (boundary) begin
            ia_d = {cur_d, {DIV_LOG2{1'b0}}};
        end else begin
            ia_d = ia_q + IaW'(step);
        end
    end

    // Envelope 32768 + (a*md)>>>8; result is always within 0..65535.
    always_comb begin
        md      = (mod_depth > 9'd256) ? 9'd256 : mod_depth;
        prod    = interp * $signed({1'b0, md});
        env     = 16'h8000 + prod[23:8];
        carrier = phase_q[PHASE_W-1] ? -$signed({2'b00, env}) : $signed({2'b00, env});
    end

    // Carrier NCO and first-order delta-sigma; both are parked at zero when disabled.
    always_comb begin
        v       = {err_q[17], err_q} + {carrier[17], carrier};
        dsm_bit = ~v[18];
        err_w   = dsm_bit ? (v - 19'sd65536) : (v + 19'sd65536);
        if (enable) begin
            phase_d = phase_q + phase_inc;
            err_d   = err_w[17:0];
            rf_d    = dsm_bit;
        end else begin
            phase_d = '0;
            err_d   = '0;
            rf_d    = 1'b0;
        end
    end

    assign unused_bits = ^{prod[25:24], prod[7:0], err_w[18]};

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            div_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cur_q       <= '0;
            target_q    <= '0;
            underrun_q  <= 1'b0;
            ia_q        <= '0;
            phase_q     <= '0;
            err_q       <= '0;
            rf_q        <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cur_q       <= cur_d;
            target_q    <= target_d;
            underrun_q  <= underrun_d;
            ia_q        <= ia_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            rf_q        <= rf_d;
        end
    end

    assign audio_ready = !hold_full_q;
    assign underrun    = underrun_q;
    assign rf_out      = rf_q;

endmodule
